// File: rtl/sh_bus_initiator_pkg.sv
// Shared Saturn bus package.
// Holds the initiator state encoding, the request record that is latched when
// an access is accepted, the idle (deasserted) levels of the active-low
// strobes, and a helper that maps byte enables onto the write strobes.
package sh_bus_initiator_pkg;

  localparam int ADDR_W = 24;  // word address, bus bits 24:1
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_T1,
    ST_T2,
    ST_TEND
  } bus_state_e;

  // Idle levels of the active-low control strobes.
  localparam logic       STB_IDLE = 1'b1;
  localparam logic [1:0] WE_IDLE  = 2'b11;

  // Access captured on acceptance; the bus cycle runs from this copy only.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [1:0]        be;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Byte enables {hi,lo} to active-low write strobes. BE=00 gives no strobe,
  // but the cycle still runs to completion.
  function automatic logic [1:0] we_strobe(input logic [1:0] be);
    return ~be;
  endfunction

endpackage

// File: rtl/sh_bus_arb.sv
// Bus-request hold logic for the Saturn bus initiator.
// Ports:
//   clk_i, rst_i    system clock, async active-high reset
//   ce_r_i          bus-clock rising enable
//   req_i           access request from the client
//   back_n_i        bus acknowledge from the arbiter
//   state_i         current initiator state
//   breq_n_o        registered bus request (active low)
//   grant_o         bus may be driven on this CE_R
// With SLAVE=0 the initiator owns the bus outright: BREQ_N idles high and
// grant is always true. With SLAVE=1 BREQ_N drops on acceptance, is held
// through the whole tenure, and is kept low across TEND when another request
// is already waiting so the following access skips arbitration.
module sh_bus_arb
  import sh_bus_initiator_pkg::*;
#(
  parameter int SLAVE = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_r_i,
  input  logic       req_i,
  input  logic       back_n_i,
  input  bus_state_e state_i,
  output logic       breq_n_o,
  output logic       grant_o
);

  logic breq_n_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      breq_n_q <= STB_IDLE;
    end else if (SLAVE != 0 && ce_r_i) begin
      case (state_i)
        // Request the bus on acceptance; let go if the client has gone quiet
        // while we were still holding it from a back-to-back TEND.
        ST_IDLE: breq_n_q <= ~req_i;
        ST_ARB:  breq_n_q <= 1'b0;
        // Keep the bus only if the next access is already requested.
        ST_TEND: breq_n_q <= ~req_i;
        default: ;
      endcase
    end
  end

  assign breq_n_o = breq_n_q;
  // BACK_N only matters for starting a tenure; once in T1/T2 it is ignored.
  assign grant_o  = (SLAVE == 0) || (!breq_n_q && !back_n_i);

endmodule

// File: rtl/sh_bus_initiator.sv
// Saturn (SH-2 style) bus initiator.
// Turns a simple REQ/ACK client access into a bus cycle:
//   IDLE -> [ARB] -> T1 -> T2 (wait states) -> TEND -> IDLE
// All state changes happen on the bus-clock enables CE_R / CE_F.
// Ports:
//   CLK, RST              system clock, async active-high reset
//   CE_R, CE_F            bus-clock rising / falling enables
//   REQ,ADDR,WR,BE,WDATA  client request (ADDR is word address 24:1)
//   ACK,RDATA,BUSY        one-CLK completion pulse, read data, in-flight flag
//   A, DO, DI             bus address, write data, read data
//   BS_N,CS0_N,RD_WR_N,RD_N,WE_N  bus control (active low)
//   WAIT_N                responder wait, sampled on CE_F in T2
//   BREQ_N, BACK_N        bus request / acknowledge (used when SLAVE=1)
module sh_bus_initiator
  import sh_bus_initiator_pkg::*;
#(
  parameter int SLAVE = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        REQ,
  input  logic [23:0] ADDR,
  input  logic        WR,
  input  logic [1:0]  BE,
  input  logic [15:0] WDATA,
  output logic        ACK,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic [23:0] A,
  output logic [15:0] DO,
  input  logic [15:0] DI,
  output logic        BS_N,
  output logic        CS0_N,
  output logic        RD_WR_N,
  output logic        RD_N,
  output logic [1:0]  WE_N,
  input  logic        WAIT_N,
  output logic        BREQ_N,
  input  logic        BACK_N
);

  bus_state_e  state_q;
  bus_req_t    req_q;
  bus_req_t    acc;
  logic        grant;
  logic        launch;
  logic        ack_q, busy_q;
  logic        bs_n_q, cs0_n_q, rd_wr_n_q, rd_n_q;
  logic [1:0]  we_n_q;
  logic [23:0] a_q;
  logic [15:0] do_q, rdata_q;

  sh_bus_arb #(.SLAVE(SLAVE)) u_arb (
    .clk_i    (CLK),
    .rst_i    (RST),
    .ce_r_i   (CE_R),
    .req_i    (REQ),
    .back_n_i (BACK_N),
    .state_i  (state_q),
    .breq_n_o (BREQ_N),
    .grant_o  (grant)
  );

  // When launching straight from IDLE the request is latched on the same edge,
  // so the bus outputs are taken from the live inputs; from ARB they come from
  // the latched copy (REQ/ADDR changes during ARB are ignored).
  always_comb begin
    acc = req_q;
    if (state_q == ST_IDLE) begin
      acc.addr  = ADDR;
      acc.wr    = WR;
      acc.be    = BE;
      acc.wdata = WDATA;
    end
  end

  assign launch = CE_R && grant &&
                  ((state_q == ST_IDLE && REQ) || state_q == ST_ARB);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      bs_n_q    <= STB_IDLE;
      cs0_n_q   <= STB_IDLE;
      rd_wr_n_q <= STB_IDLE;
      rd_n_q    <= STB_IDLE;
      we_n_q    <= WE_IDLE;
      a_q       <= '0;
      do_q      <= '0;
      rdata_q   <= '0;
    end else begin
      ack_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (CE_R && REQ) begin
            req_q   <= acc;
            busy_q  <= 1'b1;
            state_q <= launch ? ST_T1 : ST_ARB;
          end
        end
        ST_ARB: begin
          if (launch) state_q <= ST_T1;
        end
        ST_T1: begin
          if (CE_F) begin
            bs_n_q <= STB_IDLE;
            if (req_q.wr) we_n_q <= we_strobe(req_q.be);
            else          rd_n_q <= 1'b0;
            state_q <= ST_T2;
          end
        end
        ST_T2: begin
          // First sample here is a full bus cycle after the strobe went low.
          if (CE_F && WAIT_N) begin
            if (!req_q.wr) rdata_q <= DI;
            state_q <= ST_TEND;
          end
        end
        ST_TEND: begin
          if (CE_R) begin
            rd_n_q    <= STB_IDLE;
            we_n_q    <= WE_IDLE;
            cs0_n_q   <= STB_IDLE;
            rd_wr_n_q <= STB_IDLE;
            ack_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // T1 entry: address/data/direction are set here and not touched again
      // until the next launch, so they stay stable through TEND.
      if (launch) begin
        a_q       <= acc.addr;
        cs0_n_q   <= 1'b0;
        bs_n_q    <= 1'b0;
        rd_wr_n_q <= ~acc.wr;
        if (acc.wr) do_q <= acc.wdata;
      end
    end
  end

  assign ACK     = ack_q;
  assign BUSY    = busy_q;
  assign RDATA   = rdata_q;
  assign A       = a_q;
  assign DO      = do_q;
  assign BS_N    = bs_n_q;
  assign CS0_N   = cs0_n_q;
  assign RD_WR_N = rd_wr_n_q;
  assign RD_N    = rd_n_q;
  assign WE_N    = we_n_q;

endmodule

// File: tb/tb_sh_bus_initiator.sv
// Directed bench for sh_bus_initiator: one SLAVE=0 and one SLAVE=1 instance
// share the bus-side stimulus, each with its own REQ; `sel` picks which
// instance the monitor watches.
module tb_sh_bus_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_r, ce_f;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        wr = 1'b0, back_n = 1'b0, wait_n;
  logic [23:0] addr = '0;
  logic [1:0]  be = 2'b11;
  logic [15:0] wdata = '0, di = '0;

  logic        ack0, ack1, busy0, busy1, bs0, bs1, cs0, cs1;
  logic        rw0, rw1, rd0, rd1, br0, br1;
  logic [15:0] rdata0, rdata1, do0, do1;
  logic [23:0] a0, a1;
  logic [1:0]  we0, we1;

  bit          sel = 1'b0;
  int          wait_cfg = 0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  sh_bus_initiator #(.SLAVE(0)) u_dut0 (
    .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f),
    .REQ(req0), .ADDR(addr), .WR(wr), .BE(be), .WDATA(wdata),
    .ACK(ack0), .RDATA(rdata0), .BUSY(busy0),
    .A(a0), .DO(do0), .DI(di),
    .BS_N(bs0), .CS0_N(cs0), .RD_WR_N(rw0), .RD_N(rd0), .WE_N(we0),
    .WAIT_N(wait_n), .BREQ_N(br0), .BACK_N(back_n)
  );

  sh_bus_initiator #(.SLAVE(1)) u_dut1 (
    .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f),
    .REQ(req1), .ADDR(addr), .WR(wr), .BE(be), .WDATA(wdata),
    .ACK(ack1), .RDATA(rdata1), .BUSY(busy1),
    .A(a1), .DO(do1), .DI(di),
    .BS_N(bs1), .CS0_N(cs1), .RD_WR_N(rw1), .RD_N(rd1), .WE_N(we1),
    .WAIT_N(wait_n), .BREQ_N(br1), .BACK_N(back_n)
  );

  logic        m_ack, m_busy, m_cs, m_rd, m_br, m_rw;
  logic [1:0]  m_we;
  logic [23:0] m_a;
  logic [15:0] m_do;
  assign m_ack  = sel ? ack1  : ack0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_cs   = sel ? cs1   : cs0;
  assign m_rd   = sel ? rd1   : rd0;
  assign m_br   = sel ? br1   : br0;
  assign m_rw   = sel ? rw1   : rw0;
  assign m_we   = sel ? we1   : we0;
  assign m_a    = sel ? a1    : a0;
  assign m_do   = sel ? do1   : do0;

  // Bus clock = CLK/4; CE_R at phase 0, CE_F at phase 2. The same block
  // keeps free-running event counters and plays the responder's WAIT_N.
  int          ph = 0, wseen = 0;
  int          ack_cnt = 0, busy_cnt = 0, cs_low_cnt = 0, rd_low_cnt = 0;
  int          we_low_cnt = 0, br_rise = 0, unstable = 0;
  logic [1:0]  last_we = 2'b11;
  logic        cs_prev = 1'b1, br_prev = 1'b1, rw_ref = 1'b1;
  logic [23:0] a_ref = '0;
  logic [15:0] do_ref = '0;

  always @(negedge clk) begin
    ph   = (ph + 1) % 4;
    ce_r = (ph == 0);
    ce_f = (ph == 2);
    if (m_ack)  ack_cnt++;
    if (m_busy) busy_cnt++;
    if (!m_cs)  cs_low_cnt++;
    if (ce_f && !m_rd)          rd_low_cnt++;
    if (ce_f && m_we != 2'b11)  we_low_cnt++;
    if (m_we != 2'b11) last_we = m_we;
    if (m_br && !br_prev) br_rise++;
    br_prev = m_br;
    if (!m_cs) begin
      if (cs_prev) begin
        a_ref = m_a; do_ref = m_do; rw_ref = m_rw;
      end else if (m_a != a_ref || m_do != do_ref || m_rw != rw_ref) begin
        unstable++;
      end
    end
    cs_prev = m_cs;
    if (!m_rd || m_we != 2'b11) begin
      if (ce_f) begin
        wait_n = (wseen >= wait_cfg);
        wseen++;
      end
    end else begin
      wait_n = 1'b1;
      wseen  = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bounded wait for ACK, then one extra negedge so the monitor has counted it.
  task automatic wait_ack(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (m_ack) got = 1'b1;
    end
    chk(tag, {63'd0, got}, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_ce_r(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (ce_r) k++;
    end
  endtask

  initial begin
    int b_ack, b_rd, b_we, b_un, b_cs, b_br, b_busy;
    logic [15:0] r1;

    // ---- reset state
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_ctl0", {bs0, cs0, rd0, rw0, br0, we0, ack0, busy0}, 9'b1_1111_1100);
    chk("rst_bus0", {a0, do0, rdata0}, 56'd0);
    chk("rst_ctl1", {bs1, cs1, rd1, rw1, br1, we1, ack1, busy1}, 9'b1_1111_1100);
    chk("rst_bus1", {a1, do1, rdata1}, 56'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ---- SLAVE=0 read, no wait states
    sel = 1'b0; wait_cfg = 0;
    b_ack = ack_cnt; b_rd = rd_low_cnt; b_we = we_low_cnt; b_un = unstable; b_busy = busy_cnt;
    @(negedge clk);
    addr = 24'h000100; wr = 1'b0; be = 2'b11; di = 16'h1234; req0 = 1'b1;
    wait_ack("rd_tmo"); req0 = 1'b0;
    chk("rd_ack",    ack_cnt - b_ack, 1);
    chk("rd_strobe", rd_low_cnt - b_rd, 1);
    chk("rd_nowe",   we_low_cnt - b_we, 0);
    chk("rd_data",   rdata0, 16'h1234);
    chk("rd_addr",   a0, 24'h000100);
    chk("rd_busy",   {63'd0, (busy_cnt - b_busy) > 0}, 1);
    chk("rd_done",   {busy0, cs0, rd0, rw0}, 4'b0111);
    chk("rd_stable", unstable - b_un, 0);

    // ---- write to LWRAM with 5 wait states
    wait_cfg = 5;
    b_ack = ack_cnt; b_rd = rd_low_cnt; b_we = we_low_cnt; b_un = unstable;
    @(negedge clk);
    addr = 24'h200000; wr = 1'b1; be = 2'b01; wdata = 16'hBEEF; di = 16'hDEAD; req0 = 1'b1;
    wait_ack("wr_tmo"); req0 = 1'b0;
    chk("wr_ack",    ack_cnt - b_ack, 1);
    chk("wr_strobe", we_low_cnt - b_we, 6);
    chk("wr_we",     last_we, 2'b10);
    chk("wr_nord",   rd_low_cnt - b_rd, 0);
    chk("wr_do",     do0, 16'hBEEF);
    chk("wr_addr",   a0, 24'h200000);
    chk("wr_stable", unstable - b_un, 0);
    chk("wr_rdata",  rdata0, 16'h1234);
    chk("wr_idle",   {we0, cs0, rw0}, 4'b1111);

    // ---- write with no byte enables still completes
    wait_cfg = 0;
    b_ack = ack_cnt; b_we = we_low_cnt;
    @(negedge clk);
    addr = 24'h000200; wr = 1'b1; be = 2'b00; wdata = 16'h0F0F; req0 = 1'b1;
    wait_ack("be0_tmo"); req0 = 1'b0;
    chk("be0_ack", ack_cnt - b_ack, 1);
    chk("be0_we",  we_low_cnt - b_we, 0);
    chk("be0_do",  do0, 16'h0F0F);

    // ---- SLAVE=1 arbitration: BACK_N high for 4 CE_R
    sel = 1'b1; back_n = 1'b1;
    repeat (4) @(negedge clk);
    b_ack = ack_cnt; b_cs = cs_low_cnt;
    @(negedge clk);
    addr = 24'h0C0010; wr = 1'b0; be = 2'b11; di = 16'h7777; req1 = 1'b1;
    wait_ce_r(4);
    @(negedge clk);
    chk("arb_breq", br1, 1'b0);
    chk("arb_cs",   cs_low_cnt - b_cs, 0);
    back_n = 1'b0;
    wait_ce_r(1);
    #1 chk("arb_t1", cs1, 1'b0);
    wait_ack("arb_tmo"); req1 = 1'b0;
    chk("arb_ack",  ack_cnt - b_ack, 1);
    chk("arb_data", rdata1, 16'h7777);

    // ---- SLAVE=1 back-to-back reads keep the bus
    repeat (12) @(negedge clk);
    chk("b2b_idle", br1, 1'b1);
    b_ack = ack_cnt; b_br = br_rise;
    addr = 24'h000300; di = 16'hA5A5; req1 = 1'b1;
    wait_ack("b2b_tmo1");
    r1 = rdata1;
    addr = 24'h000302; di = 16'h5A5A;
    wait_ack("b2b_tmo2"); req1 = 1'b0;
    chk("b2b_acks", ack_cnt - b_ack, 2);
    chk("b2b_hold", br_rise - b_br, 0);
    chk("b2b_rd1",  r1, 16'hA5A5);
    chk("b2b_rd2",  rdata1, 16'h5A5A);
    chk("b2b_addr", a1, 24'h000302);
    repeat (12) @(negedge clk);
    chk("b2b_rel",  br1, 1'b1);

    // ---- REQ dropped while in ARB
    back_n = 1'b1;
    b_ack = ack_cnt; b_cs = cs_low_cnt;
    @(negedge clk);
    addr = 24'h0ABCDE; wr = 1'b1; be = 2'b11; wdata = 16'h1357; req1 = 1'b1;
    wait_ce_r(2);
    @(negedge clk);
    req1 = 1'b0; addr = 24'h000000; wdata = 16'h0000;
    repeat (8) @(negedge clk);
    chk("drop_wait", cs_low_cnt - b_cs, 0);
    back_n = 1'b0;
    wait_ack("drop_tmo");
    chk("drop_ack",  ack_cnt - b_ack, 1);
    chk("drop_addr", a1, 24'h0ABCDE);
    chk("drop_do",   do1, 16'h1357);
    repeat (8) @(negedge clk);
    chk("drop_rel",  {br1, busy1}, 2'b10);

    // ---- reset during T2 of a write
    sel = 1'b0; wait_cfg = 20;
    repeat (4) @(negedge clk);
    b_ack = ack_cnt;
    @(negedge clk);
    addr = 24'h000400; wr = 1'b1; be = 2'b11; wdata = 16'hCAFE; req0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (we0 != 2'b11) break;
    end
    repeat (8) @(negedge clk);
    chk("rst_pre", {we0, cs0}, 3'b000);
    rst = 1'b1; req0 = 1'b0;
    #1;
    chk("rst_we",   we0, 2'b11);
    chk("rst_cs",   {cs0, busy0, ack0}, 3'b100);
    @(negedge clk);
    rst = 1'b0; wait_cfg = 0;
    repeat (20) @(negedge clk);
    chk("rst_noack", ack_cnt - b_ack, 0);
    chk("rst_quiet", {cs0, busy0}, 2'b10);
    b_ack = ack_cnt;
    addr = 24'h000500; wr = 1'b0; di = 16'h2468; req0 = 1'b1;
    wait_ack("post_tmo"); req0 = 1'b0;
    chk("post_ack",  ack_cnt - b_ack, 1);
    chk("post_data", rdata0, 16'h2468);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sh_bus_initiator.md
SH_BUS_INITIATOR -- requirements
Module: sh_bus_initiator

Interface
REQ-001 SHALL have parameter SLAVE, default 0, meaning 1 = must win BREQ_N/BACK_N arbitration before each bus tenure.
REQ-002 SHALL have ports: CLK  in  1  system clock; RST  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: CE_R  in  1  bus-clock rising enable; CE_F  in  1  bus-clock falling enable.
REQ-004 SHALL have ports: REQ in 1 access request; ADDR in 24 (24:1) word address; WR in 1 write; BE in 2 byte enables {hi,lo}; WDATA in 16 write data.
REQ-005 SHALL have ports: ACK out 1 one-CLK completion pulse; RDATA out 16 read data; BUSY out 1 request accepted, not yet ACKed.
REQ-006 SHALL have ports: A out 24 (24:1) bus address; DO out 16 bus write data; DI in 16 bus read data.
REQ-007 SHALL have ports: BS_N, CS0_N, RD_WR_N, RD_N out 1 each; WE_N out 2 active-low byte strobes; WAIT_N in 1 responder wait.
REQ-008 SHALL have ports: BREQ_N out 1 bus request; BACK_N in 1 bus acknowledge.

Function
REQ-009 SHALL implement states IDLE, ARB, T1, T2, TEND; all transitions except reset occur only on CE_R or CE_F as stated.
REQ-010 IDLE, REQ=1, on CE_R: latch ADDR/WR/BE/WDATA, BUSY=1; go T1 if SLAVE=0 or BREQ_N already low and BACK_N=0, else ARB.
REQ-011 ARB: BREQ_N=0; on CE_R with BACK_N=0 go T1; REQ changes after acceptance are ignored.
REQ-012 Entering T1: A=latched address, CS0_N=0, BS_N=0, RD_WR_N=~WR, DO=latched data (write only).
REQ-013 T1 on CE_F: BS_N=1; read -> RD_N=0; write -> WE_N=~BE; go T2.
REQ-014 T2 on CE_F: WAIT_N=0 -> stay (wait state); WAIT_N=1 -> latch DI into RDATA if read, go TEND.
REQ-015 WAIT_N SHALL be sampled no earlier than the first CE_F after strobe assertion (minimum one full bus cycle of strobe).
REQ-016 TEND on CE_R: RD_N=1, WE_N=2'b11, CS0_N=1, RD_WR_N=1; ACK=1 for exactly one CLK; BUSY=0; go IDLE.
REQ-017 SLAVE=1: BREQ_N held low from ARB through TEND; released at TEND unless REQ=1 at that CE_R (back-to-back, next access skips ARB).
REQ-018 BE=2'b00 write SHALL still run a full cycle with WE_N=2'b11 and ACK.
REQ-019 A, DO, RD_WR_N SHALL stay stable from T1 entry until TEND exit.
REQ-020 BACK_N deasserting during T1/T2 SHALL NOT abort the access.

Reset
REQ-021 RST=1 SHALL immediately force state IDLE, BS_N=CS0_N=RD_N=RD_WR_N=BREQ_N=1, WE_N=2'b11, ACK=BUSY=0, A=0, DO=0, RDATA=0.
REQ-022 RST asserted mid-access SHALL abandon the access without ACK; no pending request survives reset.

Structure
REQ-023 State enum and strobe idle constants SHALL live in the shared Saturn bus package.
REQ-024 SHALL be a single module; an optional sub-module sh_bus_arb (ARB/BREQ_N hold logic) is permitted.

Verification
REQ-025 SLAVE=0, read 0x000100, WAIT_N=1 always, DI=0x1234 -> RD_N low exactly one bus cycle, RDATA=0x1234, one ACK.
REQ-026 Write 0x200000 (LWRAM) BE=2'b01 WDATA=0xBEEF, WAIT_N low 5 CE_F -> WE_N=2'b10 for 6 bus cycles, DO=0xBEEF stable, one ACK.
REQ-027 SLAVE=1, BACK_N held high 4 CE_R then low -> BREQ_N low, CS0_N stays high until first CE_R with BACK_N=0.
REQ-028 SLAVE=1, two back-to-back reads, REQ high at first TEND -> BREQ_N never deasserts between them, two ACKs.
REQ-029 RST pulsed during T2 of a write -> WE_N=2'b11, CS0_N=1 same CLK, no ACK, next REQ completes normally.
REQ-030 REQ dropped during ARB -> access still completes with latched address and ACK.
